// File: rtl/sr_trace_uart_tx.sv
// sr_trace_uart_tx: hardware trace transmitter for sr_cpu.
// Buffers {pc, instr, a0} records in a small FIFO and streams each one out as
// a UART 8N1 frame: 0xA5 sync byte, then pc, instr and a0, each LSB-first.
// Optional feature macro SR_TRACE_CHECKSUM_EN appends one XOR checksum byte
// covering every byte after the sync byte.
module sr_trace_uart_tx #(
   parameter int CLK_DIV = 16,
   parameter int DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   trace_valid,
   input  logic [31:0]            trace_pc,
   input  logic [31:0]            trace_instr,
   input  logic [31:0]            trace_a0,
   output logic                   uart_tx,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [7:0]             drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(CLK_DIV);
`ifdef SR_TRACE_CHECKSUM_EN
   localparam int FRAME_BYTES = 14;
`else
   localparam int FRAME_BYTES = 13;
`endif
   localparam int FW = FRAME_BYTES * 8;
   localparam logic [3:0]    LAST_BYTE = 4'(FRAME_BYTES - 1);
   localparam logic [TW-1:0] T_LAST    = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_EARLY   = TW'(CLK_DIV - 2);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t        state, next_state;
   logic [TW-1:0] timer, timer_next;
   logic [2:0]    bit_idx, bit_idx_next;
   logic [3:0]    byte_idx, byte_idx_next;
   logic          tick;

   logic [95:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          empty, full, push, pop, drop;
   logic [95:0]   head;
   logic [FW-1:0] frame_load, shift_buf;
   logic          shift_byte, tx_next;

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head       = mem[rd_ptr[AW-1:0]];
   assign push       = trace_valid && (!full || pop);
   assign drop       = trace_valid && full && !pop;
   assign fifo_level = wr_ptr - rd_ptr;
   assign busy       = (state != IDLE) || (fifo_level != '0);
   assign tick       = (timer == T_LAST);

`ifdef SR_TRACE_CHECKSUM_EN
   logic [7:0] csum;

   // XOR of the twelve payload bytes of the record at the FIFO head
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
      csum = '0;
      for (int i = 0; i < 12; i++) csum ^= head[8*i +: 8];
   end

   assign frame_load = {csum, head, 8'hA5};
`else
   assign frame_load = {head, 8'hA5};
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only, so all flops sample the same edge.
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state and counter update logic
   always_comb begin
      next_state    = state;
      timer_next    = '0;
      bit_idx_next  = bit_idx;
      byte_idx_next = byte_idx;
      unique case (state)
         IDLE:  if (!empty) next_state = LOAD;
         LOAD:  next_state = START;
         START: if (tick) next_state = DATA;
         DATA:  if (tick && bit_idx == 3'd7) next_state = STOP;
         STOP: begin
            if (byte_idx != LAST_BYTE) begin
               if (tick) next_state = START;
            end
            // LOAD takes the final clock of the stop bit so the next frame is gapless
            else if (!empty && (tick || timer == T_EARLY)) next_state = LOAD;
            else if (tick) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (next_state == state && (state inside {START, DATA, STOP}) && !tick)
         timer_next = timer + 1'b1;
      if (state == DATA && tick) bit_idx_next = bit_idx + 3'd1;
      if (state == STOP && next_state == START)         byte_idx_next = byte_idx + 4'd1;
      else if (next_state == LOAD || next_state == IDLE) byte_idx_next = '0;
   end

   // FSM outputs: FIFO pop, byte advance and the next serial line level
   always_comb begin
      pop        = (next_state == LOAD);
      shift_byte = (state == STOP) && (next_state == START);
      tx_next    = 1'b1;
      case (next_state)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_buf[bit_idx_next];
         default: tx_next = 1'b1;
      endcase
   end

   // Bit/byte counters and registered serial output
   always_ff @(posedge clk) begin
      if (rst) begin
         timer    <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         uart_tx  <= 1'b1;
      end else begin
         timer    <= timer_next;
         bit_idx  <= bit_idx_next;
         byte_idx <= byte_idx_next;
         uart_tx  <= tx_next;
      end
   end

   // Frame shift buffer: loaded on pop, advanced one byte per stop->start
   always_ff @(posedge clk) begin
      if (pop)             shift_buf <= frame_load;
      else if (shift_byte) shift_buf <= shift_buf >> 8;
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers alone define which entries are valid.
      if (push) mem[wr_ptr[AW-1:0]] <= {trace_a0, trace_instr, trace_pc};
   end

   // FIFO pointers and saturating drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         drop_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule
